// File: rtl/tl_burst_arbiter.sv
// Two-master TileLink-UL arbiter feeding one slave (DDR3 adapter A/D).
// Ports: clk, reset_n; mN_a_* / mN_d_* per master; s_a_* / s_d_* to slave.
module tl_burst_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int SOURCE_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     m0_a_valid,
    output logic                     m0_a_ready,
    input  logic [2:0]               m0_a_opcode,
    input  logic [SOURCE_WIDTH-1:0]  m0_a_source,
    input  logic [ADDRESS_WIDTH-1:0] m0_a_address,
    input  logic [63:0]              m0_a_data,
    output logic                     m0_d_valid,
    input  logic                     m0_d_ready,
    output logic [2:0]               m0_d_opcode,
    output logic [SOURCE_WIDTH-1:0]  m0_d_source,
    output logic [63:0]              m0_d_data,

    input  logic                     m1_a_valid,
    output logic                     m1_a_ready,
    input  logic [2:0]               m1_a_opcode,
    input  logic [SOURCE_WIDTH-1:0]  m1_a_source,
    input  logic [ADDRESS_WIDTH-1:0] m1_a_address,
    input  logic [63:0]              m1_a_data,
    output logic                     m1_d_valid,
    input  logic                     m1_d_ready,
    output logic [2:0]               m1_d_opcode,
    output logic [SOURCE_WIDTH-1:0]  m1_d_source,
    output logic [63:0]              m1_d_data,

    output logic                     s_a_valid,
    input  logic                     s_a_ready,
    output logic [2:0]               s_a_opcode,
    output logic [SOURCE_WIDTH:0]    s_a_source,
    output logic [ADDRESS_WIDTH-1:0] s_a_address,
    output logic [63:0]              s_a_data,
    input  logic                     s_d_valid,
    output logic                     s_d_ready,
    input  logic [2:0]               s_d_opcode,
    input  logic [SOURCE_WIDTH:0]    s_d_source,
    input  logic [63:0]              s_d_data
);

    localparam logic IDLE = 1'b0;
    localparam logic LOCK = 1'b1;

    logic       state;
    logic [2:0] beat;
    logic       rr_last;
    logic       hold;
    logic       owner;

    logic       locked;
    logic       win;
    logic       win_valid;
    logic       is_get;
    logic       fire;
    logic       d_sel;

    // Grant is frozen by a pending stalled beat or an open PutFull burst.
    always_comb begin
        locked = (state == LOCK) | hold;
        if (locked) begin
            win = owner;
        end else if (m0_a_valid ^ m1_a_valid) begin
            win = m1_a_valid;
        end else begin
            win = ~rr_last;
        end
    end

    always_comb begin
        win_valid   = win ? m1_a_valid : m0_a_valid;
        s_a_valid   = reset_n & win_valid;
        s_a_opcode  = win ? m1_a_opcode  : m0_a_opcode;
        s_a_address = win ? m1_a_address : m0_a_address;
        s_a_data    = win ? m1_a_data    : m0_a_data;
        s_a_source  = {win, (win ? m1_a_source : m0_a_source)};
        m0_a_ready  = reset_n & ~win & s_a_ready;
        m1_a_ready  = reset_n &  win & s_a_ready;
        is_get      = s_a_opcode[2];
        fire        = s_a_valid & s_a_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            beat    <= 3'd0;
            rr_last <= 1'b1;
            hold    <= 1'b0;
            owner   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        hold <= 1'b0;
                        if (is_get) begin
                            rr_last <= win;
                        end else begin
                            state <= LOCK;
                            beat  <= 3'd1;
                            owner <= win;
                        end
                    end else if (s_a_valid) begin
                        hold  <= 1'b1;
                        owner <= win;
                    end
                end
                LOCK: begin
                    if (fire) begin
                        if (beat == 3'd7) begin
                            state   <= IDLE;
                            beat    <= 3'd0;
                            rr_last <= owner;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // D responses are steered by the prepended owner bit, no beat counting.
    always_comb begin
        d_sel       = s_d_source[SOURCE_WIDTH];
        m0_d_valid  = reset_n & s_d_valid & ~d_sel;
        m1_d_valid  = reset_n & s_d_valid &  d_sel;
        s_d_ready   = reset_n & (d_sel ? m1_d_ready : m0_d_ready);
        m0_d_opcode = s_d_opcode;
        m1_d_opcode = s_d_opcode;
        m0_d_source = s_d_source[SOURCE_WIDTH-1:0];
        m1_d_source = s_d_source[SOURCE_WIDTH-1:0];
        m0_d_data   = s_d_data;
        m1_d_data   = s_d_data;
    end

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Directed bench for tl_burst_arbiter.
// Drives after posedge, checks combinational outputs before next edge.
module tb_tl_burst_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_a_valid, m0_a_ready;
    logic [2:0]  m0_a_opcode;
    logic [3:0]  m0_a_source;
    logic [31:0] m0_a_address;
    logic [63:0] m0_a_data;
    logic        m0_d_valid, m0_d_ready;
    logic [2:0]  m0_d_opcode;
    logic [3:0]  m0_d_source;
    logic [63:0] m0_d_data;
    logic        m1_a_valid, m1_a_ready;
    logic [2:0]  m1_a_opcode;
    logic [3:0]  m1_a_source;
    logic [31:0] m1_a_address;
    logic [63:0] m1_a_data;
    logic        m1_d_valid, m1_d_ready;
    logic [2:0]  m1_d_opcode;
    logic [3:0]  m1_d_source;
    logic [63:0] m1_d_data;
    logic        s_a_valid, s_a_ready;
    logic [2:0]  s_a_opcode;
    logic [4:0]  s_a_source;
    logic [31:0] s_a_address;
    logic [63:0] s_a_data;
    logic        s_d_valid, s_d_ready;
    logic [2:0]  s_d_opcode;
    logic [4:0]  s_d_source;
    logic [63:0] s_d_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tl_burst_arbiter #(.ADDRESS_WIDTH(32), .SOURCE_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_a_opcode(m0_a_opcode), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_source(m0_d_source),
        .m0_d_data(m0_d_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_a_opcode(m1_a_opcode), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_source(m1_d_source),
        .m1_d_data(m1_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_opcode(s_a_opcode), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .s_d_opcode(s_d_opcode), .s_d_source(s_d_source),
        .s_d_data(s_d_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_a_valid = 0; m0_a_opcode = 3'd4; m0_a_source = 0;
        m0_a_address = 0; m0_a_data = 0; m0_d_ready = 0;
        m1_a_valid = 0; m1_a_opcode = 3'd4; m1_a_source = 0;
        m1_a_address = 0; m1_a_data = 0; m1_d_ready = 0;
        s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0;
        s_d_source = 0; s_d_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
        #1;
    endtask

    initial begin
        // Reset gating with live inputs
        idle_inputs();
        reset_n = 0;
        m0_a_valid = 1; s_a_ready = 1;
        s_d_valid = 1; m0_d_ready = 1;
        #1;
        check("rst_s_a_valid", s_a_valid, 0);
        check("rst_m0_a_ready", m0_a_ready, 0);
        check("rst_m0_d_valid", m0_d_valid, 0);
        check("rst_s_d_ready", s_d_ready, 0);
        step();
        do_reset();

        // Single Get
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_source = 4'd3;
        m0_a_address = 32'h1000; s_a_ready = 1;
        #1;
        check("get_valid", s_a_valid, 1);
        check("get_source", s_a_source, 5'h03);
        check("get_addr", s_a_address, 32'h1000);
        check("get_m0_ready", m0_a_ready, 1);
        check("get_m1_ready", m1_a_ready, 0);
        step();
        m0_a_valid = 0;
        #1;
        check("get_done", s_a_valid, 0);

        // Round-robin with continuous Gets
        do_reset();
        m0_a_valid = 1; m0_a_source = 4'd1;
        m1_a_valid = 1; m1_a_source = 4'd2;
        s_a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_source", s_a_source,
                  (i % 2 == 0) ? 64'h01 : 64'h12);
            check("rr_m0_ready", m0_a_ready, (i % 2 == 0) ? 1 : 0);
            step();
        end

        // PutFull lock from m1, m0 waiting with a Get
        do_reset();
        m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_source = 4'd9;
        m1_a_data = 0; s_a_ready = 1;
        #1;
        check("put_b0_src", s_a_source, 5'h19);
        check("put_b0_ready", m1_a_ready, 1);
        step();
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_source = 4'd2;
        for (int i = 1; i < 8; i++) begin
            m1_a_data = 64'(i);
            if (i == 4) begin
                m1_a_valid = 0;
                #1;
                check("put_stall_valid", s_a_valid, 0);
                check("put_stall_m0_ready", m0_a_ready, 0);
                step();
                m1_a_valid = 1;
            end
            #1;
            check("put_data", s_a_data, 64'(i));
            check("put_src", s_a_source, 5'h19);
            check("put_m0_ready", m0_a_ready, 0);
            check("put_m1_ready", m1_a_ready, 1);
            step();
        end
        m1_a_data = 64'd8;
        #1;
        check("put_after_src", s_a_source, 5'h02);
        check("put_after_m0_ready", m0_a_ready, 1);
        check("put_after_m1_ready", m1_a_ready, 0);
        step();
        m0_a_valid = 0;
        #1;
        check("put_next_src", s_a_source, 5'h19);

        // Stability while the slave stalls
        do_reset();
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_source = 4'd7;
        s_a_ready = 1;
        step();
        s_a_ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_source = 4'd5;
            end
            #1;
            check("stab_src", s_a_source, 5'h07);
            check("stab_m1_ready", m1_a_ready, 0);
            step();
        end
        s_a_ready = 1;
        #1;
        check("stab_fire_src", s_a_source, 5'h07);
        check("stab_fire_ready", m0_a_ready, 1);
        step();
        m0_a_valid = 0;
        #1;
        check("stab_next_src", s_a_source, 5'h15);

        // D routing to m1
        do_reset();
        s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = 5'h15;
        for (int i = 0; i < 8; i++) begin
            s_d_data = 64'(i * 3);
            m1_d_ready = i[0];
            m0_d_ready = 1;
            #1;
            check("d_m1_valid", m1_d_valid, 1);
            check("d_m0_valid", m0_d_valid, 0);
            check("d_m1_source", m1_d_source, 4'd5);
            check("d_s_ready", s_d_ready, i[0]);
            check("d_m0_data", m0_d_data, 64'(i * 3));
            step();
        end
        s_d_source = 5'h02; m0_d_ready = 1; m1_d_ready = 0;
        #1;
        check("d_m0_route", m0_d_valid, 1);
        check("d_m0_sready", s_d_ready, 1);
        check("d_m0_source", m0_d_source, 4'd2);

        // Reset mid-burst
        do_reset();
        m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_source = 4'd9;
        s_a_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m1_a_data = 64'(i);
            step();
        end
        reset_n = 0;
        #1;
        check("mid_rst_valid", s_a_valid, 0);
        check("mid_rst_m1_ready", m1_a_ready, 0);
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_source = 4'd6;
        #1;
        check("mid_rst_valid2", s_a_valid, 0);
        check("mid_rst_m0_ready", m0_a_ready, 0);
        step();
        reset_n = 1;
        #1;
        check("post_rst_src", s_a_source, 5'h06);
        check("post_rst_m0_ready", m0_a_ready, 1);
        check("post_rst_m1_ready", m1_a_ready, 0);
        step();
        m0_a_valid = 0;
        #1;
        check("post_rst_next", s_a_source, 5'h19);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
